// File: rtl/relax_osc_pkg.sv
// ============================================================================
// relax_osc_pkg : shared types and constants for the relaxation-osc controller
// Rev 1.0
// ============================================================================
`default_nettype none

package relax_osc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // One-hot cap0 select; users slice the low N_CAP bits.
    localparam logic [31:0] SEL_RESET = 32'd1;

endpackage

`default_nettype wire

// File: rtl/relax_osc_ctrl_cmp_sync.sv
// ============================================================================
// cmp_sync : multi-stage synchroniser for the comparator plus rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module cmp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], cmp_i};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

`default_nettype wire

// File: rtl/relax_osc_ctrl.sv
// ============================================================================
// relax_osc_ctrl : windowed edge counter and capacitor rotator for a
//                  comparator-driven relaxation oscillator
// Rev 1.0
// ============================================================================
`default_nettype none

module relax_osc_ctrl
    import relax_osc_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int N_CAP       = 2,
    parameter int WIN_W       = 16,
    parameter int RST_CYC     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             cmp,
    output logic             rst_out,
    output logic [N_CAP-1:0] sel_cap,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             ovf
);

    localparam int              BLK_W    = $clog2(RST_CYC + 1);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(RST_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic [BLK_W-1:0] blank_q;
    logic [N_CAP-1:0] sel_q;
    logic             rst_out_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             ovf_q;

    logic             w_rise;
    logic             w_accept;
    logic [WIN_W-1:0] w_win_load;

    cmp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_i  (cmp),
        .rise_o (w_rise)
    );

    assign w_accept   = (state_q == MEASURE) && (blank_q == '0) && w_rise;
    assign w_win_load = (win_len == '0) ? WIN_W'(1) : win_len;

    // Saturating counter; the edge of the final window cycle must reach count.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_int_d  = ovf_int_q;
        if (w_accept) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_int_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            ovf_int_q  <= 1'b0;
            blank_q    <= '0;
            sel_q      <= SEL_RESET[N_CAP-1:0];
            rst_out_q  <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // Blanking runs independently of the FSM so an aborted window's pulse completes.
            if (w_accept) begin
                sel_q     <= {sel_q[N_CAP-2:0], sel_q[N_CAP-1]};
                blank_q   <= BLK_LOAD;
                rst_out_q <= 1'b1;
            end else if (blank_q != '0) begin
                blank_q   <= blank_q - BLK_W'(1);
                rst_out_q <= (blank_q != BLK_W'(1));
            end else begin
                rst_out_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q    <= MEASURE;
                        edge_cnt_q <= '0;
                        ovf_int_q  <= 1'b0;
                        win_cnt_q  <= w_win_load;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else begin
                        edge_cnt_q <= edge_cnt_d;
                        ovf_int_q  <= ovf_int_d;
                        if (win_cnt_q == WIN_W'(1)) begin
                            state_q <= DONE;
                            count_q <= edge_cnt_d;
                            ovf_q   <= ovf_int_d;
                            valid_q <= 1'b1;
                        end else begin
                            win_cnt_q <= win_cnt_q - WIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (en) begin
                        state_q    <= MEASURE;
                        edge_cnt_q <= '0;
                        ovf_int_q  <= 1'b0;
                        win_cnt_q  <= w_win_load;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign sel_cap = sel_q;
    assign count   = count_q;
    assign valid   = valid_q;
    assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_relax_osc_ctrl.sv
// ============================================================================
// tb_relax_osc_ctrl : self-checking bench for relax_osc_ctrl (4-bit count,
//                     3 caps, 4-cycle reset pulse)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_relax_osc_ctrl;

    localparam int CNT_W       = 4;
    localparam int N_CAP       = 3;
    localparam int WIN_W       = 16;
    localparam int RST_CYC     = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIN_W-1:0] win_len;
    logic             cmp;
    logic             rst_out;
    logic [N_CAP-1:0] sel_cap;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             ovf;

    relax_osc_ctrl #(
        .CNT_W       (CNT_W),
        .N_CAP       (N_CAP),
        .WIN_W       (WIN_W),
        .RST_CYC     (RST_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .win_len (win_len),
        .cmp     (cmp),
        .rst_out (rst_out),
        .sel_cap (sel_cap),
        .count   (count),
        .valid   (valid),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int wl;
        int npulse;
        int spacing;
        int high;
        int acc;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [N_CAP-1:0] sel_exp;
    vec_t             tbl[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic pulse_at(input int j, input vec_t v);
        int k;
        int r;
        if (j < 3) return 1'b0;
        k = (j - 3) / v.spacing;
        r = (j - 3) % v.spacing;
        return (k < v.npulse) && (r < v.high);
    endfunction

    task automatic rotate_exp(input int n);
        for (int k = 0; k < n; k++) sel_exp = {sel_exp[N_CAP-2:0], sel_exp[N_CAP-1]};
    endtask

    // Scoreboard consumer: every valid strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("count", int'(count), int'(e.cnt));
                check("ovf", int'(ovf), int'(e.ovf));
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_window(input vec_t v);
        int wt;
        int c0;
        int rst_hi;
        exp_t e;
        wt      = (v.wl == 0) ? 1 : v.wl;
        rst_hi  = 0;
        c0      = cyc;
        en      = 1'b1;
        win_len = WIN_W'(v.wl);
        e.cnt   = CNT_W'(v.exp_cnt);
        e.ovf   = v.exp_ovf;
        e.cyc   = c0 + wt + 1;
        sb.push_back(e);
        for (int j = 0; j <= wt; j++) begin
            cmp = pulse_at(j, v);
            if (j == 5) win_len = 16'd7;
            tick();
            if (rst_out) rst_hi++;
        end
        en  = 1'b0;
        cmp = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (rst_out) rst_hi++;
        end
        check("valid_seen_pending", sb.size(), 0);
        sb.delete();
        rotate_exp(v.acc);
        check("sel_cap", int'(sel_cap), int'(sel_exp));
        check("rst_out_cycles", rst_hi, v.acc * RST_CYC);
    endtask

    initial begin
        vec_t pv;

        //          wl   np sp hi acc cnt ovf
        tbl[0]  = '{100,  5, 10, 3,  5,  5, 1'b0};
        tbl[1]  = '{300, 20, 10, 3, 20, 15, 1'b1};
        tbl[2]  = '{100,  3, 10, 3,  3,  3, 1'b0};
        tbl[3]  = '{ 50,  2,  4, 2,  1,  1, 1'b0};
        tbl[4]  = '{ 60,  6,  4, 2,  3,  3, 1'b0};
        tbl[5]  = '{100,  8,  5, 2,  8,  8, 1'b0};
        tbl[6]  = '{  0,  0, 10, 3,  0,  0, 1'b0};
        tbl[7]  = '{  1,  0, 10, 3,  0,  0, 1'b0};
        tbl[8]  = '{200, 15, 10, 3, 15, 15, 1'b0};
        tbl[9]  = '{200, 16, 10, 3, 16, 15, 1'b1};
        tbl[10] = '{ 40,  0, 10, 3,  0,  0, 1'b0};

        rst_n   = 1'b0;
        en      = 1'b0;
        cmp     = 1'b0;
        win_len = '0;
        sel_exp = N_CAP'(1);
        tick();
        tick();
        check("reset_rst_out", int'(rst_out), 0);
        check("reset_sel_cap", int'(sel_cap), 1);
        check("reset_count", int'(count), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 11; i++) run_window(tbl[i]);

        // Back-to-back windows with en held: a strobe every win_len+1 cycles.
        begin
            int   c0;
            exp_t e;
            c0      = cyc;
            en      = 1'b1;
            win_len = 16'd10;
            for (int k = 1; k <= 3; k++) begin
                e.cnt = '0;
                e.ovf = 1'b0;
                e.cyc = c0 + 11 * k;
                sb.push_back(e);
            end
            for (int j = 0; j < 33; j++) tick();
            en = 1'b0;
            for (int j = 0; j < 3; j++) tick();
            check("b2b_pending", sb.size(), 0);
            sb.delete();
        end

        // Establish a non-zero count, then abort a window mid-way.
        pv = '{10, 1, 10, 3, 1, 1, 1'b0};
        run_window('{100, 3, 10, 3, 3, 3, 1'b0});
        pv = '{100, 4, 10, 3, 4, 0, 1'b0};
        en      = 1'b1;
        win_len = 16'd100;
        for (int j = 0; j < 50; j++) begin
            cmp = pulse_at(j, pv);
            tick();
        end
        en  = 1'b0;
        cmp = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        rotate_exp(4);
        check("abort_count_hold", int'(count), 3);
        check("abort_ovf_hold", int'(ovf), 0);
        check("abort_sel_cap", int'(sel_cap), int'(sel_exp));
        check("abort_rst_out_done", int'(rst_out), 0);

        // Asynchronous reset while a reset pulse is in flight.
        pv = '{100, 5, 10, 3, 5, 5, 1'b0};
        en      = 1'b1;
        win_len = 16'd100;
        for (int j = 0; j < 27; j++) begin
            cmp = pulse_at(j, pv);
            tick();
        end
        check("pre_reset_rst_out", int'(rst_out), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", int'(rst_out), 0);
        check("async_sel_cap", int'(sel_cap), 1);
        check("async_count", int'(count), 0);
        check("async_valid", int'(valid), 0);
        check("async_ovf", int'(ovf), 0);
        en      = 1'b0;
        cmp     = 1'b0;
        sel_exp = N_CAP'(1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        check("post_reset_idle_valid", int'(valid), 0);
        check("post_reset_idle_sel", int'(sel_cap), 1);
        check("post_reset_idle_count", int'(count), 0);
        pv = '{10, 1, 10, 3, 1, 1, 1'b0};
        run_window(pv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
